// File: rtl/fifo_stream_out.sv
// Drain stage for a block-RAM FIFO: turns read-enable/not-empty with 1-cycle read data
// into a valid/ready stream using a 2-entry skid buffer, with flush and a delivered-word count.
module fifo_stream_out #(
    parameter int unsigned DATA_ = 8,
    parameter int unsigned CNT_  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty_,
    output logic             fifo_re,
    input  logic [DATA_-1:0] fifo_dout,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATA_-1:0] out_data,
    output logic [CNT_-1:0]  count
);

    logic [1:0]      occ_q, occ_d;
    logic            inflight_q, inflight_d;
    logic            drop_q, drop_d;
    logic            head_q, head_d;
    logic            tail_q, tail_d;
    logic [CNT_-1:0] count_q, count_d;
    logic [DATA_-1:0] buf_q [2];

    logic       pop;
    logic       capture;
    logic [2:0] pending;

    // Credit check counts buffered, in-flight and departing words so the buffer can never overflow.
    always_comb begin
        out_valid  = !rst && !flush && (occ_q != 2'd0);
        pop        = out_valid && out_ready;
        pending    = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        fifo_re    = !rst && !flush && fifo_empty_ && (pending < 3'd2);
        capture    = inflight_q && !drop_q && !flush;

        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = fifo_re;
        drop_d     = flush && inflight_q;

        if (flush) begin
            occ_d  = 2'd0;
            head_d = 1'b0;
            tail_d = 1'b0;
        end else begin
            if (capture) begin
                tail_d = !tail_q;
            end
            if (pop) begin
                head_d  = !head_q;
                count_d = count_q + CNT_'(1);
            end
            occ_d = 2'(3'(occ_q) + 3'(capture) - 3'(pop));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Data storage needs no reset; it is only observed while out_valid is high.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            buf_q[tail_q] <= fifo_dout;
        end
    end

    assign out_data = buf_q[head_q];
    assign count    = count_q;

endmodule
